wb_rr_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 27 ++
 rtl/rr_priority_pick.sv | 41 ++++
 rtl/wb_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and helpers for the Wishbone round-robin arbiter
//
// Contents: arbiter state encoding, the MAX_MASTERS limit, and a one-hot to
// index encoder sized for MAX_MASTERS requesters.
package wb_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // Returns the index of the set bit; the input is expected to be one-hot
  // (or zero, which yields index 0).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      if (oh[k]) idx = idx | IDX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin winner selection
//
// Ports:
//   req_i    : request vector, one bit per requester
//   last_i   : index of the previous winner
//   onehot_o : one-hot winner (zero when nothing requests)
//   idx_o    : winner index
//   valid_o  : at least one request present
module rr_priority_pick
  import wb_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic found;
  int   cand;

  // Walk upward from last+1, wrapping at N; the first requester found wins.
  always_comb begin
    onehot_o = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_i) + i) % N;
      if (!found && req_i[cand]) begin
        onehot_o[cand] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign idx_o   = onehot_to_idx(MAX_MASTERS'(onehot_o));
  assign valid_o = found;

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone arbiter, N masters onto one slave
//
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort stalled strobes with err.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   m_adr_i/m_dat_i/m_sel_i    : packed per-master address, write data, selects
//   m_we_i/m_cyc_i/m_stb_i     : per-master control
//   m_dat_o/m_ack_o/m_err_o    : read data broadcast, per-master ack and abort
//   s_*_o / s_dat_i / s_ack_i  : slave-side Wishbone port
//   grant_o, busy_o            : registered one-hot grant, non-idle flag
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      busy_o
);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       last_q, last_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   granted_cyc;
  logic                   in_grant;
  logic                   abort_hit;

  rr_priority_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i    (m_cyc_i),
    .last_i   (last_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  assign in_grant    = (state_q == ST_GRANT);
  assign granted_cyc = |(m_cyc_i & grant_q);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        stall;

  // Counter holds the number of stalled cycles already seen, so the
  // TIMEOUT_CYCLES-th stall is the one where it equals TIMEOUT_CYCLES-1.
  // An ack in that cycle removes the stall and therefore wins.
  assign stall     = in_grant && s_stb_o && !s_ack_i;
  assign abort_hit = stall && granted_cyc && (wd_cnt_q == WD_LIMIT);
  assign wd_cnt_d  = (stall && !abort_hit) ? wd_cnt_q + 16'd1 : 16'd0;
  assign m_err_o   = abort_hit ? grant_q : '0;

  always_ff @(posedge clk) begin
    if (reset) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`else
  assign abort_hit = 1'b0;
  assign m_err_o   = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
        end
      end
      ST_GRANT: begin
        // Release has priority over a coincident watchdog expiry.
        if (!granted_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end else if (abort_hit) begin
          state_d = ST_ABORT;
          grant_d = '0;
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        last_d  = gidx_q;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

  // Slave-side mux; everything is zero outside GRANT (covers IDLE and ABORT).
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (in_grant) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (grant_q[k]) begin
          s_adr_o = m_adr_i[k*32 +: 32];
          s_dat_o = m_dat_i[k*32 +: 32];
          s_sel_o = m_sel_i[k*4 +: 4];
          s_we_o  = m_we_i[k];
          s_cyc_o = m_cyc_i[k];
          s_stb_o = m_stb_i[k];
        end
      end
    end
  end

  assign m_ack_o = in_grant ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_dat_o = in_grant ? s_dat_i : 32'd0;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - directed self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [32*N-1:0] m_adr_i, m_dat_i;
  logic [4*N-1:0] m_sel_i;
  logic [N-1:0]   m_we_i, m_cyc_i, m_stb_i;
  logic [31:0]    m_dat_o;
  logic [N-1:0]   m_ack_o, m_err_o;
  logic [31:0]    s_adr_o, s_dat_o;
  logic [3:0]     s_sel_o;
  logic           s_we_o, s_cyc_o, s_stb_o;
  logic [31:0]    s_dat_i;
  logic           s_ack_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  int errors = 0;
  int checks = 0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [N-1:0] v);
    m_cyc_i = v;
    m_stb_i = v;
  endtask

  initial begin
    m_adr_i = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    m_dat_i = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    m_sel_i = {4'h8, 4'h4, 4'h2, 4'h1};
    m_we_i  = 4'b0100;
    req(4'b0000);
    s_dat_i = 32'hDEAD_BEEF;
    s_ack_i = 1'b0;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_scyc", s_cyc_o, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_err", m_err_o, 0);
    check("rst_sadr", s_adr_o, 0);

    // Masters 0 and 2 request together; master 0 wins first.
    req(4'b0101);
    #1;
    check("t1_pre_scyc", s_cyc_o, 0);
    tick();
    check("t1_grant0", grant_o, 4'b0001);
    check("t1_sadr0", s_adr_o, 32'hA000_0000);
    check("t1_ssel0", s_sel_o, 4'h1);
    check("t1_scyc", s_cyc_o, 1);
    check("t1_busy", busy_o, 1);
    s_ack_i = 1'b1;
    #1;
    check("t1_ack", m_ack_o, 4'b0001);
    check("t1_mdat", m_dat_o, 32'hDEAD_BEEF);
    s_ack_i = 1'b0;
    req(4'b0100);
    #1;
    check("t1_rel_scyc", s_cyc_o, 0);
    tick();
    check("t1_gap_grant", grant_o, 4'b0000);
    check("t1_gap_busy", busy_o, 0);
    check("t1_gap_scyc", s_cyc_o, 0);
    tick();
    check("t1_grant2", grant_o, 4'b0100);
    check("t1_sadr2", s_adr_o, 32'hA000_0002);
    check("t1_swe2", s_we_o, 1);
    check("t1_sdat2", s_dat_o, 32'hD000_0002);
    req(4'b0000);
    tick();

    // All four request continuously with single-ack transfers.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req(4'b1111);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_grant_%0d", i), grant_o, 32'(1 << (i % 4)));
      s_ack_i = 1'b1;
      m_cyc_i[i % 4] = 1'b0;
      #1;
      check($sformatf("t2_ack_%0d", i), m_ack_o, 32'(1 << (i % 4)));
      tick();
      check($sformatf("t2_idle_%0d", i), busy_o, 0);
      s_ack_i = 1'b0;
      m_cyc_i[i % 4] = 1'b1;
    end
    req(4'b0000);
    tick();

    // Master 1 bursts six acks while master 3 waits. Last winner is 0.
    req(4'b1010);
    tick();
    check("t3_grant1", grant_o, 4'b0010);
    for (int i = 0; i < 6; i++) begin
      s_ack_i = 1'b1;
      #1;
      check($sformatf("t3_ack_%0d", i), m_ack_o, 4'b0010);
      tick();
      check($sformatf("t3_hold_%0d", i), grant_o, 4'b0010);
    end
    s_ack_i = 1'b0;
    req(4'b1000);
    tick();
    check("t3_gap", grant_o, 4'b0000);
    tick();
    check("t3_grant3", grant_o, 4'b1000);
    check("t3_sadr3", s_adr_o, 32'hA000_0003);
    req(4'b0000);
    tick();

    // Stalled slave on master 0 (last winner is 3).
    req(4'b0001);
    tick();
    check("t4_grant0", grant_o, 4'b0001);
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c < 10; c++) begin
      check($sformatf("t4_noerr_%0d", c), m_err_o, 0);
      tick();
    end
    check("t4_err", m_err_o, 4'b0001);
    tick();
    check("t4_abort_scyc", s_cyc_o, 0);
    check("t4_abort_busy", busy_o, 1);
    check("t4_abort_err", m_err_o, 0);
    tick();
    check("t4_idle_busy", busy_o, 0);
    tick();
    check("t4_regrant", grant_o, 4'b0001);
    for (int c = 1; c < 10; c++) tick();
    s_ack_i = 1'b1;
    #1;
    check("t4_acklimit_err", m_err_o, 0);
    check("t4_acklimit_ack", m_ack_o, 4'b0001);
    tick();
    s_ack_i = 1'b0;
    #1;
    check("t4_acklimit_hold", grant_o, 4'b0001);
    check("t4_acklimit_err2", m_err_o, 0);
`else
    for (int c = 1; c <= 20; c++) begin
      check($sformatf("t4_noerr_%0d", c), m_err_o, 0);
      tick();
    end
    check("t4_stall_hold", grant_o, 4'b0001);
`endif
    req(4'b0000);
    tick();
    tick();

    // Reset during an active strobe.
    req(4'b0100);
    tick();
    check("t5_grant2", grant_o, 4'b0100);
    check("t5_sstb", s_stb_o, 1);
    reset = 1'b1;
    tick();
    check("t5_rst_grant", grant_o, 0);
    check("t5_rst_scyc", s_cyc_o, 0);
    check("t5_rst_busy", busy_o, 0);
    reset = 1'b0;
    req(4'b0101);
    tick();
    check("t5_grant0", grant_o, 4'b0001);
    req(4'b0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
